systolic_sequencer: RTL
=======================

// Module: systolic_sequencer
// PURPOSE
//  Controller that sequences one NxN matrix multiply on the systolic PE array inside the integrated top.
//  On start it clears the array, streams A columns and B rows from the operand memories through
//  triangular skew buffers onto the array's west and north edges, then flushes the array.
//  It then drains the result rows into the result memory and raises finish.
//  Sits between the UART-loaded operand/result memories and the PE array.
// PARAMETERS
//  N   4  array dimension; also matrix size and number of k-steps
//  DW  8  operand element width
//  AW  2  operand/result memory address width; must satisfy 2**AW >= N
// PORTS
//  clk         in   1     single system clock, rising edge
//  rst         in   1     asynchronous, active-low reset
//  start       in   1     level request; sampled only in IDLE
//  finish      out  1     high in DONE; held until start is low
//  busy        out  1     high in every state except IDLE and DONE
//  op_rd_en    out  1     read strobe to the A and B memories
//  op_addr     out  AW    k index; same address is used for both memories
//  a_col       in   N*DW  column k of A; valid one cycle after op_rd_en
//  b_row       in   N*DW  row k of B; valid one cycle after op_rd_en
//  west_data   out  N*DW  skewed A elements to array row inputs; slice i is row i
//  north_data  out  N*DW  skewed B elements to array column inputs; slice j is column j
//  array_en    out  1     PE MAC/shift enable
//  array_clr   out  1     synchronous accumulator clear to PEs
//  row_sel     out  AW    array result-row mux select
//  res_we      out  1     result memory write strobe
//  res_addr    out  AW    result memory row address; equals row_sel
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; all counters 0; skew registers 0; every output 0.
//  Reset mid-run aborts immediately; no partial result write completes after rst asserts.
//  FSM, one registered state and one counter cnt:
//  - IDLE: if start=1, go to CLEAR.
//  - CLEAR: 1 cycle. array_clr=1. Go to FEED with cnt=0.
//  - FEED: N cycles. op_rd_en=1, op_addr=cnt, array_en=1. At cnt=N-1 go to FLUSH with cnt=0.
//  - FLUSH: 2N-1 cycles. array_en=1, op_rd_en=0. The skew inputs are fed zeros.
//    At cnt=2N-2 go to DRAIN with cnt=0.
//  - DRAIN: N cycles. row_sel=res_addr=cnt, res_we=1, array_en=0. At cnt=N-1 go to DONE.
//  - DONE: finish=1. Go to IDLE when start=0. If start stays high, no restart occurs.
//  Skew:
//  - Memory data arriving in cycle t enters the skew buffers.
//  - Row i (or column j) of the skew output is delayed by i (or j) additional cycles.
//  - Skew inputs are forced to 0 whenever the previous cycle had no op_rd_en, so zeros pad the wavefront.
//  - The last MAC lands on PE(N-1,N-1) 3N-2 cycles after the first FEED cycle, inside FLUSH.
//  Latency: finish rises 4N+1 cycles after the cycle in which start is sampled high (N=4: 17).
//  start toggling during busy is ignored; a run always completes unless reset.
//  Outputs are registered from state/cnt; there are no combinational paths from start to outputs.
//  cnt width is clog2(2N); all arithmetic is unsigned and never wraps within a state.
// STRUCTURE
//  - Shared header sa_defines.vh holds: state encodings (IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE),
//    default N/DW/AW, and the FLUSH_LEN=2N-1 expression. The PE array and the UART loader also use it.
//  - Sub-module systolic_skew (parameters N, DW) is a triangular delay line with lane i delayed i cycles.
//    It uses the same async active-low reset and is instantiated twice (west and north).
//  - The top contains the FSM, cnt, and output registers.
// TESTING
//  1. Reset: rst=0 for 3 cycles at any state -> all outputs 0, state IDLE; release -> outputs stay 0.
//  2. Timing, N=4, start held high:
//     - array_clr in cycle 1; op_addr 0,1,2,3 in cycles 2-5; array_en high cycles 2-12;
//     - res_we cycles 13-16 with res_addr 0..3; finish=1 from cycle 17.
//  3. Skew: a_col={4,3,2,1} at addr 0, others 0 -> west slice0=1 @c3, slice1=2 @c4,
//     slice2=3 @c5, slice3=4 @c6, zeros otherwise.
//  4. End-to-end with PE model: A=B=identity -> result rows 0001,0010,0100,1000;
//     A=all 2, B=all 3 -> every result element = 24.
//  5. Handshake: start pulsed 1 cycle then low -> run completes; finish rises then falls the next cycle.
//     start held high -> finish stays high and no second run starts.
//  6. Reset mid-DRAIN (after res_addr=1 is written) -> res_we drops asynchronously; the next start runs a full clean sequence.

Source files
------------

// File: rtl/systolic_sequencer_pkg.sv
// Shared types and defaults for the systolic-array sequencer: state encoding,
// the registered control bundle, and the flush-length helper.
package systolic_sequencer_pkg;

  localparam int unsigned SA_N  = 4;
  localparam int unsigned SA_DW = 8;
  localparam int unsigned SA_AW = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } sa_state_e;

  typedef struct packed {
    logic busy;
    logic finish;
    logic op_rd_en;
    logic array_en;
    logic array_clr;
    logic res_we;
  } sa_ctrl_t;

  // Cycles needed for the last skewed operand to cross the whole array.
  function automatic int unsigned flush_len(input int unsigned n);
    return 2 * n - 1;
  endfunction

  function automatic sa_ctrl_t ctrl_decode(input sa_state_e s);
    sa_ctrl_t c;
    c = '0;
    case (s)
      S_CLEAR: begin
        c.busy      = 1'b1;
        c.array_clr = 1'b1;
      end
      S_FEED: begin
        c.busy     = 1'b1;
        c.op_rd_en = 1'b1;
        c.array_en = 1'b1;
      end
      S_FLUSH: begin
        c.busy     = 1'b1;
        c.array_en = 1'b1;
      end
      S_DRAIN: begin
        c.busy   = 1'b1;
        c.res_we = 1'b1;
      end
      S_DONE:  c.finish = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/systolic_sequencer_if.sv
// Bus between the sequencer and its environment: handshake, operand memory
// read port, skewed array edges, array control and result memory write port.
interface systolic_sequencer_if #(
  parameter int unsigned N  = systolic_sequencer_pkg::SA_N,
  parameter int unsigned DW = systolic_sequencer_pkg::SA_DW,
  parameter int unsigned AW = systolic_sequencer_pkg::SA_AW
) ();

  logic            start;
  logic            finish;
  logic            busy;
  logic            op_rd_en;
  logic [AW-1:0]   op_addr;
  logic [N*DW-1:0] a_col;
  logic [N*DW-1:0] b_row;
  logic [N*DW-1:0] west_data;
  logic [N*DW-1:0] north_data;
  logic            array_en;
  logic            array_clr;
  logic [AW-1:0]   row_sel;
  logic            res_we;
  logic [AW-1:0]   res_addr;

  modport master (
    output start, a_col, b_row,
    input  finish, busy, op_rd_en, op_addr, west_data, north_data,
           array_en, array_clr, row_sel, res_we, res_addr
  );

  modport slave (
    input  start, a_col, b_row,
    output finish, busy, op_rd_en, op_addr, west_data, north_data,
           array_en, array_clr, row_sel, res_we, res_addr
  );

endinterface

// File: rtl/systolic_sequencer_skew.sv
// Triangular delay line: lane i of the output is lane i of the input delayed
// by i clock cycles (lane 0 passes straight through).
module systolic_skew #(
  parameter int unsigned N  = systolic_sequencer_pkg::SA_N,
  parameter int unsigned DW = systolic_sequencer_pkg::SA_DW
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [N*DW-1:0] i_data,
  output logic [N*DW-1:0] o_data
);

  for (genvar i = 0; i < N; i++) begin : g_lane
    if (i == 0) begin : g_pass
      assign o_data[DW-1:0] = i_data[DW-1:0];
    end else begin : g_delay
      logic [DW-1:0] r_pipe [i];

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          for (int unsigned s = 0; s < i; s++) r_pipe[s] <= '0;
        end else begin
          r_pipe[0] <= i_data[i*DW +: DW];
          for (int unsigned s = 1; s < i; s++) r_pipe[s] <= r_pipe[s-1];
        end
      end

      assign o_data[i*DW +: DW] = r_pipe[i-1];
    end
  end

endmodule

// File: rtl/systolic_sequencer.sv
// Sequences one NxN systolic matrix multiply: clear, feed skewed operands,
// flush the array, drain result rows into the result memory, then finish.
module systolic_sequencer
  import systolic_sequencer_pkg::*;
#(
  parameter int unsigned N  = SA_N,
  parameter int unsigned DW = SA_DW,
  parameter int unsigned AW = SA_AW
) (
  input  logic                clk,
  input  logic                rst,
  systolic_sequencer_if.slave bus
);

  localparam int unsigned   CW         = $clog2(2 * N);
  localparam logic [CW-1:0] FEED_LAST  = CW'(N - 1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(flush_len(N) - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(N - 1);

  sa_state_e       r_state;
  sa_state_e       w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  sa_ctrl_t        r_ctrl;
  sa_ctrl_t        w_ctrl_nxt;
  logic [AW-1:0]   r_op_addr;
  logic [AW-1:0]   r_row_sel;
  logic            r_rd_en_d;
  logic [N*DW-1:0] w_west_in;
  logic [N*DW-1:0] w_north_in;
  logic [N*DW-1:0] w_west_out;
  logic [N*DW-1:0] w_north_out;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        w_state_nxt = S_FEED;
        w_cnt_nxt   = '0;
      end
      S_FEED: begin
        if (r_cnt == FEED_LAST) begin
          w_state_nxt = S_FLUSH;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_FLUSH: begin
        if (r_cnt == FLUSH_LAST) begin
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_cnt == DRAIN_LAST) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DONE: begin
        if (!bus.start) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state
  // they describe while still coming straight out of flops.
  assign w_ctrl_nxt = ctrl_decode(w_state_nxt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_ctrl    <= '0;
      r_op_addr <= '0;
      r_row_sel <= '0;
      r_rd_en_d <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ctrl    <= w_ctrl_nxt;
      r_op_addr <= w_ctrl_nxt.op_rd_en ? AW'(w_cnt_nxt) : '0;
      r_row_sel <= w_ctrl_nxt.res_we   ? AW'(w_cnt_nxt) : '0;
      r_rd_en_d <= r_ctrl.op_rd_en;
    end
  end

  // Memory data is only meaningful the cycle after a read; zero it otherwise
  // so the wavefront is padded with zeros during flush.
  assign w_west_in  = r_rd_en_d ? bus.a_col : '0;
  assign w_north_in = r_rd_en_d ? bus.b_row : '0;

  systolic_skew #(.N(N), .DW(DW)) u_west_skew (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_data  (w_west_in),
    .o_data  (w_west_out)
  );

  systolic_skew #(.N(N), .DW(DW)) u_north_skew (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_data  (w_north_in),
    .o_data  (w_north_out)
  );

  assign bus.west_data  = w_west_out;
  assign bus.north_data = w_north_out;
  assign bus.busy       = r_ctrl.busy;
  assign bus.finish     = r_ctrl.finish;
  assign bus.op_rd_en   = r_ctrl.op_rd_en;
  assign bus.op_addr    = r_op_addr;
  assign bus.array_en   = r_ctrl.array_en;
  assign bus.array_clr  = r_ctrl.array_clr;
  assign bus.row_sel    = r_row_sel;
  assign bus.res_we     = r_ctrl.res_we;
  assign bus.res_addr   = r_row_sel;

endmodule
